// File: rtl/snake_pkg.sv
// Shared types and defaults for the scanline snake renderer.
package snake_pkg;

  localparam int unsigned X_W = 7;
  localparam int unsigned Y_W = 6;

  localparam logic [11:0] HEAD_COLOUR = 12'h5C0;
  localparam logic [11:0] TAIL_COLOUR = 12'h5D1;

  typedef enum logic [1:0] {StIdle, StClear, StScan, StDone} scan_state_e;

  typedef struct packed {
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
  } vga_timing_t;

  // Code 0 = empty, 1 = head, k+2 = tail segment k.
  function automatic int unsigned code_w(input int unsigned max_seg);
    return $clog2(max_seg + 2);
  endfunction

endpackage

// File: rtl/snake_row_scanner.sv
// Per-line scanner: during hblank walks head + tail segments and builds the
// occupancy codes for the next line, then publishes them at the end of hblank.
module snake_row_scanner #(
  parameter int unsigned MAX_SEG   = 16,
  parameter int unsigned X_W       = snake_pkg::X_W,
  parameter int unsigned Y_W       = snake_pkg::Y_W,
  parameter int unsigned CELL_LOG2 = 4,
  parameter int unsigned COLS      = 64,
  parameter int unsigned V_LAST    = 627,
  parameter int unsigned CW        = snake_pkg::code_w(MAX_SEG),
  parameter int unsigned LW        = $clog2(MAX_SEG + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        hblnk_i,
  input  logic [10:0]                 vcount_i,
  input  logic [X_W-1:0]              head_x_i,
  input  logic [Y_W-1:0]              head_y_i,
  input  logic [MAX_SEG*X_W-1:0]      tail_x_i,
  input  logic [MAX_SEG*Y_W-1:0]      tail_y_i,
  input  logic [LW-1:0]               len_i,
  output logic [COLS-1:0][CW-1:0]     active_o,
  output logic                        overrun_o
);
  import snake_pkg::*;

  localparam int unsigned IW  = $clog2(MAX_SEG + 1);
  localparam int unsigned CIW = (COLS > 1) ? $clog2(COLS) : 1;

  scan_state_e              state_q, state_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic [10:0]              tgt_row_q, tgt_row_d;
  logic                     hblnk_q;
  logic [COLS-1:0][CW-1:0]  shadow_q, shadow_d;
  logic [COLS-1:0][CW-1:0]  active_q, active_d;
  logic                     overrun_q, overrun_d;

  logic                     hblnk_rise, hblnk_fall;
  logic [10:0]              next_line;
  logic [X_W-1:0]           ent_x;
  logic [Y_W-1:0]           ent_y;
  logic                     ent_vld;

  assign hblnk_rise = hblnk_i & ~hblnk_q;
  assign hblnk_fall = ~hblnk_i & hblnk_q;
  assign next_line  = (vcount_i == 11'(V_LAST)) ? '0 : vcount_i + 11'd1;

  // Entry 0 is the head; entry k+1 is tail segment k.
  always_comb begin
    ent_x   = head_x_i;
    ent_y   = head_y_i;
    ent_vld = 1'b1;
    if (idx_q != '0) begin
      ent_x   = tail_x_i[(int'(idx_q) - 1) * X_W +: X_W];
      ent_y   = tail_y_i[(int'(idx_q) - 1) * Y_W +: Y_W];
      ent_vld = (32'(idx_q) - 32'd1) < 32'(len_i);
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tgt_row_d = tgt_row_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    overrun_d = overrun_q;
    unique case (state_q)
      StIdle: begin
        if (hblnk_rise) begin
          tgt_row_d = next_line >> CELL_LOG2;
          state_d   = StClear;
        end
      end
      StClear, StScan: begin
        if (hblnk_fall) begin
          overrun_d = 1'b1;
          active_d  = '0;
          state_d   = StIdle;
        end else if (state_q == StClear) begin
          shadow_d = '0;
          idx_d    = '0;
          state_d  = StScan;
        end else begin
          // First writer wins, so lower codes take priority.
          if (ent_vld && (11'(ent_y) == tgt_row_q) && (32'(ent_x) < COLS) &&
              (shadow_q[CIW'(ent_x)] == '0)) begin
            shadow_d[CIW'(ent_x)] = CW'(32'(idx_q) + 32'd1);
          end
          if (32'(idx_q) == MAX_SEG) state_d = StDone;
          else                       idx_d   = idx_q + 1'b1;
        end
      end
      StDone: begin
        if (hblnk_fall) begin
          active_d = shadow_q;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      tgt_row_q <= '0;
      hblnk_q   <= 1'b0;
      shadow_q  <= '0;
      active_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      tgt_row_q <= tgt_row_d;
      hblnk_q   <= hblnk_i;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      overrun_q <= overrun_d;
    end
  end

  assign active_o  = active_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/draw_snake_scan.sv
// Snake overlay stage: frame-coherent position snapshot feeding a row scanner,
// plus a 2-cycle pixel pipeline compositing head/tail colours over rgb_in.
module draw_snake_scan #(
  parameter int unsigned MAX_SEG     = 16,
  parameter int unsigned X_W         = snake_pkg::X_W,
  parameter int unsigned Y_W         = snake_pkg::Y_W,
  parameter int unsigned CELL_LOG2   = 4,
  parameter int unsigned COLS        = 64,
  parameter int unsigned V_LAST      = 627,
  parameter logic [11:0] HEAD_COLOUR = snake_pkg::HEAD_COLOUR,
  parameter logic [11:0] TAIL_COLOUR = snake_pkg::TAIL_COLOUR,
  parameter int unsigned GRADIENT    = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [10:0]            hcount_in,
  input  logic                   hsync_in,
  input  logic                   hblnk_in,
  input  logic [10:0]            vcount_in,
  input  logic                   vsync_in,
  input  logic                   vblnk_in,
  input  logic [11:0]            rgb_in,
  input  logic [X_W-1:0]         head_x,
  input  logic [Y_W-1:0]         head_y,
  input  logic [MAX_SEG*X_W-1:0] tail_x,
  input  logic [MAX_SEG*Y_W-1:0] tail_y,
  input  logic [4:0]             length,
  output logic [10:0]            hcount_out,
  output logic                   hsync_out,
  output logic                   hblnk_out,
  output logic [10:0]            vcount_out,
  output logic                   vsync_out,
  output logic                   vblnk_out,
  output logic [11:0]            rgb_out,
  output logic                   scan_overrun
);
  import snake_pkg::*;

  localparam int unsigned CW  = code_w(MAX_SEG);
  localparam int unsigned LW  = $clog2(MAX_SEG + 1);
  localparam int unsigned CIW = (COLS > 1) ? $clog2(COLS) : 1;

  logic                   vsync_q;
  logic [X_W-1:0]         head_x_q, head_x_d;
  logic [Y_W-1:0]         head_y_q, head_y_d;
  logic [MAX_SEG*X_W-1:0] tail_x_q, tail_x_d;
  logic [MAX_SEG*Y_W-1:0] tail_y_q, tail_y_d;
  logic [LW-1:0]          len_q, len_d;

  vga_timing_t            tim1_q, tim1_d, tim2_q;
  logic [CW-1:0]          code_q, code_d;
  logic [11:0]            rgb1_q, rgb2_q, rgb2_d;
  logic [10:0]            col;
  logic [COLS-1:0][CW-1:0] active;

  always_comb begin
    head_x_d = head_x_q;
    head_y_d = head_y_q;
    tail_x_d = tail_x_q;
    tail_y_d = tail_y_q;
    len_d    = len_q;
    if (vsync_in && !vsync_q) begin
      head_x_d = head_x;
      head_y_d = head_y;
      tail_x_d = tail_x;
      tail_y_d = tail_y;
      len_d    = (32'(length) > MAX_SEG) ? LW'(MAX_SEG) : LW'(length);
    end
  end

  snake_row_scanner #(
    .MAX_SEG   (MAX_SEG),
    .X_W       (X_W),
    .Y_W       (Y_W),
    .CELL_LOG2 (CELL_LOG2),
    .COLS      (COLS),
    .V_LAST    (V_LAST),
    .CW        (CW),
    .LW        (LW)
  ) u_scanner (
    .clk       (clk),
    .reset     (reset),
    .hblnk_i   (hblnk_in),
    .vcount_i  (vcount_in),
    .head_x_i  (head_x_q),
    .head_y_i  (head_y_q),
    .tail_x_i  (tail_x_q),
    .tail_y_i  (tail_y_q),
    .len_i     (len_q),
    .active_o  (active),
    .overrun_o (scan_overrun)
  );

  assign col = hcount_in >> CELL_LOG2;

  always_comb begin
    tim1_d = '{hcount: hcount_in, hsync: hsync_in, hblnk: hblnk_in,
               vcount: vcount_in, vsync: vsync_in, vblnk: vblnk_in};
    code_d = (32'(col) < COLS) ? active[CIW'(col)] : '0;
  end

  always_comb begin
    rgb2_d = rgb1_q;
    if (!(tim1_q.hblnk || tim1_q.vblnk) && (code_q != '0)) begin
      if (code_q == CW'(1))   rgb2_d = HEAD_COLOUR;
      else if (GRADIENT != 0) rgb2_d = TAIL_COLOUR + 12'(code_q - CW'(2));
      else                    rgb2_d = TAIL_COLOUR;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vsync_q  <= 1'b0;
      head_x_q <= '0;
      head_y_q <= '0;
      tail_x_q <= '0;
      tail_y_q <= '0;
      len_q    <= '0;
      tim1_q   <= '0;
      tim2_q   <= '0;
      code_q   <= '0;
      rgb1_q   <= '0;
      rgb2_q   <= '0;
    end else begin
      vsync_q  <= vsync_in;
      head_x_q <= head_x_d;
      head_y_q <= head_y_d;
      tail_x_q <= tail_x_d;
      tail_y_q <= tail_y_d;
      len_q    <= len_d;
      tim1_q   <= tim1_d;
      tim2_q   <= tim1_q;
      code_q   <= code_d;
      rgb1_q   <= rgb_in;
      rgb2_q   <= rgb2_d;
    end
  end

  assign hcount_out = tim2_q.hcount;
  assign hsync_out  = tim2_q.hsync;
  assign hblnk_out  = tim2_q.hblnk;
  assign vcount_out = tim2_q.vcount;
  assign vsync_out  = tim2_q.vsync;
  assign vblnk_out  = tim2_q.vblnk;
  assign rgb_out    = rgb2_q;

endmodule

// File: tb/tb_draw_snake_scan.sv
// Directed bench for draw_snake_scan using compact 192+hblank-pixel lines.
module tb_draw_snake_scan;

  localparam int unsigned ACT = 192;
  localparam int unsigned HBL = 40;

  logic         clk = 1'b0;
  logic         reset;
  logic [10:0]  hcount_in, vcount_in;
  logic         hsync_in, hblnk_in, vsync_in, vblnk_in;
  logic [11:0]  rgb_in;
  logic [6:0]   head_x;
  logic [5:0]   head_y;
  logic [111:0] tail_x;
  logic [95:0]  tail_y;
  logic [4:0]   length;

  logic [10:0]  hcount_out, vcount_out, f_hcount, f_vcount;
  logic         hsync_out, hblnk_out, vsync_out, vblnk_out, scan_overrun;
  logic         f_hsync, f_hblnk, f_vsync, f_vblnk, f_overrun;
  logic [11:0]  rgb_out, f_rgb;

  int unsigned  vectors = 0;
  int unsigned  miscompares = 0;
  logic [11:0]  out_line  [ACT];
  logic [11:0]  flat_line [ACT];
  logic [10:0]  hc_line   [ACT];
  logic [10:0]  vc_seen;

  always #5 clk = ~clk;

  draw_snake_scan dut (
    .clk(clk), .reset(reset), .hcount_in(hcount_in), .hsync_in(hsync_in),
    .hblnk_in(hblnk_in), .vcount_in(vcount_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .head_x(head_x), .head_y(head_y), .tail_x(tail_x), .tail_y(tail_y),
    .length(length), .hcount_out(hcount_out), .hsync_out(hsync_out), .hblnk_out(hblnk_out),
    .vcount_out(vcount_out), .vsync_out(vsync_out), .vblnk_out(vblnk_out), .rgb_out(rgb_out),
    .scan_overrun(scan_overrun)
  );

  draw_snake_scan #(.GRADIENT(0)) dut_flat (
    .clk(clk), .reset(reset), .hcount_in(hcount_in), .hsync_in(hsync_in),
    .hblnk_in(hblnk_in), .vcount_in(vcount_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .head_x(head_x), .head_y(head_y), .tail_x(tail_x), .tail_y(tail_y),
    .length(length), .hcount_out(f_hcount), .hsync_out(f_hsync), .hblnk_out(f_hblnk),
    .vcount_out(f_vcount), .vsync_out(f_vsync), .vblnk_out(f_vblnk), .rgb_out(f_rgb),
    .scan_overrun(f_overrun)
  );

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Pass-through colour of pixel h is 12'h100 + h. Output seen after the
  // edge that follows pixel h belongs to pixel h-1 (2-cycle latency).
  task automatic run_line(input int unsigned vc, input int unsigned hbl);
    for (int h = 0; h < int'(ACT + hbl); h++) begin
      hcount_in = 11'(h);
      hblnk_in  = (h >= int'(ACT));
      hsync_in  = (h >= int'(ACT) + 2) && (h < int'(ACT) + 6);
      vcount_in = 11'(vc);
      vblnk_in  = 1'b0;
      vsync_in  = 1'b0;
      rgb_in    = 12'h100 + 12'(h);
      @(posedge clk); #1;
      if (h >= 1 && h - 1 < int'(ACT)) begin
        out_line[h-1]  = rgb_out;
        flat_line[h-1] = f_rgb;
        hc_line[h-1]   = hcount_out;
        vc_seen        = vcount_out;
      end
    end
  endtask

  task automatic pulse_vsync();
    hblnk_in = 1'b1;
    vblnk_in = 1'b1;
    vsync_in = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    vsync_in = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic set_seg(input int k, input logic [6:0] x, input logic [5:0] y);
    tail_x[k*7 +: 7] = x;
    tail_y[k*6 +: 6] = y;
  endtask

  initial begin
    reset = 1'b1;
    hcount_in = '0; vcount_in = '0; hsync_in = 0; hblnk_in = 1'b1;
    vsync_in = 0; vblnk_in = 0; rgb_in = 12'h0AB;
    head_x = '0; head_y = '0; tail_x = '0; tail_y = '0; length = '0;
    #2;
    check("reset_rgb", rgb_out, 12'h000);
    check("reset_hcount", hcount_out, 12'h000);
    check("reset_hblnk", hblnk_out, 12'h000);
    check("reset_overrun", scan_overrun, 12'h000);
    @(posedge clk); #1;
    reset = 1'b0;

    // Head only at cell (2,3): lines 48..63, hcount 32..47.
    head_x = 7'd2; head_y = 6'd3; length = 5'd0;
    pulse_vsync();
    run_line(47, HBL);
    run_line(48, HBL);
    check("head_l48_h32", out_line[32], 12'h5C0);
    check("head_l48_h47", out_line[47], 12'h5C0);
    check("pass_l48_h31", out_line[31], 12'h11F);
    check("pass_l48_h48", out_line[48], 12'h130);
    run_line(62, HBL);
    run_line(63, HBL);
    check("head_l63_h40", out_line[40], 12'h5C0);
    run_line(64, HBL);
    check("pass_l64_h40", out_line[40], 12'h128);

    // Asynchronous reset in the middle of a line.
    hcount_in = 11'd40; vcount_in = 11'd48; hblnk_in = 1'b0; rgb_in = 12'h0AB;
    repeat (3) begin @(posedge clk); #1; end
    check("pre_reset_hcount", hcount_out, 12'd40);
    check("pre_reset_rgb", rgb_out, 12'h0AB);
    #2 reset = 1'b1;
    #1;
    check("midline_reset_rgb", rgb_out, 12'h000);
    check("midline_reset_hcount", hcount_out, 12'h000);
    check("midline_reset_vcount", vcount_out, 12'h000);
    @(posedge clk); #1;
    reset = 1'b0;
    run_line(99, HBL);
    run_line(100, HBL);
    check("post_reset_pass_h32", out_line[32], 12'h120);
    check("hcount_latency", hc_line[37], 12'd37);
    check("vcount_latency", vc_seen, 12'd100);

    // Head and seg0 on the same cell: head wins; then seg0 moves right.
    head_x = 7'd5; head_y = 6'd5; length = 5'd1;
    set_seg(0, 7'd5, 6'd5);
    pulse_vsync();
    run_line(79, HBL);
    run_line(80, HBL);
    check("head_prio_h85", out_line[85], 12'h5C0);
    check("head_prio_flat_h85", flat_line[85], 12'h5C0);
    check("pass_l80_h100", out_line[100], 12'h164);
    set_seg(0, 7'd6, 6'd5);
    pulse_vsync();
    run_line(80, HBL);
    run_line(81, HBL);
    check("head_l81_h85", out_line[85], 12'h5C0);
    check("seg0_l81_h100", out_line[100], 12'h5D1);
    check("seg0_flat_l81_h100", flat_line[100], 12'h5D1);

    // Gradient: seg3 at (11,2), seg4 at (10,2), then length 4 drops seg4.
    set_seg(3, 7'd11, 6'd2);
    set_seg(4, 7'd10, 6'd2);
    length = 5'd5;
    pulse_vsync();
    run_line(32, HBL);
    run_line(33, HBL);
    check("seg4_grad_h165", out_line[165], 12'h5D5);
    check("seg4_flat_h165", flat_line[165], 12'h5D1);
    check("seg3_grad_h180", out_line[180], 12'h5D4);
    check("seg3_flat_h180", flat_line[180], 12'h5D1);
    length = 5'd4;
    pulse_vsync();
    run_line(33, HBL);
    run_line(34, HBL);
    check("len4_seg4_gone_h165", out_line[165], 12'h1A5);
    check("len4_seg3_kept_h180", out_line[180], 12'h5D4);

    // Mid-frame head move is ignored until the next vsync rise.
    head_x = 7'd2; head_y = 6'd3; length = 5'd0;
    pulse_vsync();
    run_line(47, HBL);
    head_x = 7'd9;
    run_line(48, HBL);
    check("stale_head_h35", out_line[35], 12'h5C0);
    check("stale_no_h150", out_line[150], 12'h196);
    pulse_vsync();
    run_line(47, HBL);
    run_line(48, HBL);
    check("moved_head_h150", out_line[150], 12'h5C0);
    check("moved_old_h35", out_line[35], 12'h123);

    // Too-short hblank: scan overruns, line is pass-through, flag is sticky.
    check("overrun_clear", scan_overrun, 12'h000);
    run_line(47, 10);
    run_line(48, HBL);
    check("overrun_line_h150", out_line[150], 12'h196);
    check("overrun_set", scan_overrun, 12'h001);
    run_line(49, HBL);
    check("recover_h150", out_line[150], 12'h5C0);
    check("overrun_sticky", scan_overrun, 12'h001);
    #2 reset = 1'b1;
    #1;
    check("overrun_reset", scan_overrun, 12'h000);
    @(posedge clk); #1;
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/draw_snake_scan.md
Name: draw_snake_scan

Overview:
- Parametrised successor to the per-pixel snake renderer; sits in the VGA timing chain after background/food draw, before the output register stage.
- Replaces the per-pixel priority comparator chain with:
  - a per-line scanner that, during horizontal blanking, walks the head plus MAX_SEG tail segments and builds a row-occupancy buffer for the next line;
  - a 2-stage pixel pipeline that reads that buffer during active video.
- Adds a frame-coherent position snapshot, a configurable segment count and an optional colour gradient.

Parameters:
- MAX_SEG, 16, maximum number of tail segments.
- X_W, 7, width of one x cell coordinate.
- Y_W, 6, width of one y cell coordinate.
- CELL_LOG2, 4, log2 of cell size in pixels (cell = 16 px).
- COLS, 64, cells per line held in the row buffer.
- V_LAST, 627, last vcount of a frame (800x600@60 timing).
- HEAD_COLOUR, 12'h5C0, head colour.
- TAIL_COLOUR, 12'h5D1, base tail colour.
- GRADIENT, 1, 1 = segment k coloured TAIL_COLOUR+k; 0 = flat TAIL_COLOUR.

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- hcount_in  in  11  horizontal pixel count
- hsync_in  in  1  horizontal sync
- hblnk_in  in  1  horizontal blanking
- vcount_in  in  11  vertical line count
- vsync_in  in  1  vertical sync
- vblnk_in  in  1  vertical blanking
- rgb_in  in  12  upstream pixel colour
- head_x  in  X_W  head cell column
- head_y  in  Y_W  head cell row
- tail_x  in  MAX_SEG*X_W  segment k at [k*X_W +: X_W]
- tail_y  in  MAX_SEG*Y_W  segment k at [k*Y_W +: Y_W]
- length  in  5  number of valid tail segments
- hcount_out  out  11  hcount_in delayed 2 cycles
- hsync_out  out  1  hsync_in delayed 2 cycles
- hblnk_out  out  1  hblnk_in delayed 2 cycles
- vcount_out  out  11  vcount_in delayed 2 cycles
- vsync_out  out  1  vsync_in delayed 2 cycles
- vblnk_out  out  1  vblnk_in delayed 2 cycles
- rgb_out  out  12  composited colour
- scan_overrun  out  1  sticky flag: a scan did not finish before active video

Behaviour:
Reset (asynchronous, reset=1):
- All outputs, pipeline registers, row buffers, snapshot and FSM state clear to 0.
- FSM goes to IDLE.
- A reset mid-scan aborts the scan; the next line renders rgb_in pass-through.

Snapshot:
- On the rising edge of vsync_in (registered compare), latch head_x/y, tail_x/y and length.
- Inputs changing mid-frame have no effect until the next vsync rise.
- Latched length is saturated: min(length, MAX_SEG).

Scanner FSM (IDLE -> CLEAR -> SCAN -> DONE -> IDLE):
- IDLE -> CLEAR: on the rising edge of hblnk_in.
  - Compute next_line = (vcount_in == V_LAST) ? 0 : vcount_in + 1.
  - Compute tgt_row = next_line >> CELL_LOG2.
- CLEAR (1 cycle): zero all COLS entries of the shadow buffer.
- SCAN: index i runs 0..MAX_SEG, one entry per cycle.
  - i=0 is the head; i=k+1 is tail segment k, valid only if k < length.
  - If the entry's y == tgt_row, x < COLS, and shadow[x] == 0: write code i+1.
  - Otherwise no write. Lower code wins, so head beats tail and a low segment beats a high one.
- DONE: hold until the falling edge of hblnk_in, then copy shadow to the active buffer and go to IDLE.
- Scan latency is MAX_SEG+3 cycles, which must fit within hblank (256 cycles at default timing).
- If the falling edge of hblnk_in arrives while in CLEAR or SCAN:
  - set scan_overrun;
  - load an all-zero active buffer;
  - return to IDLE.
- scan_overrun clears only on reset.

Pixel pipeline (latency exactly 2 cycles):
- Stage 1: col = hcount_in >> CELL_LOG2; code = (col < COLS) ? active[col] : 0. Register code, rgb_in and the blank flags.
- Stage 2 colour select:
  - blanking (hblnk or vblnk) or code 0 -> rgb_in;
  - code 1 -> HEAD_COLOUR;
  - code k+2 -> TAIL_COLOUR + (GRADIENT ? k : 0), modulo 2^12.
- All timing signals are delayed through the same 2 stages.

Width rules:
- Code width is clog2(MAX_SEG+2).
- Cell x/y comparisons are zero-extended.

Decomposition:
- snake_pkg holds:
  - HEAD_COLOUR / TAIL_COLOUR defaults;
  - X_W / Y_W;
  - the code-width function;
  - FSM state encoding.
- Sub-module snake_row_scanner holds the FSM, the shadow/active buffers and the overrun flag.
- The top level holds the snapshot registers and the pixel pipeline.

Test Plan:
- Reset pulse mid-line -> all outputs 0 immediately (asynchronous); after release with no snake in range, rgb_out = rgb_in two cycles later.
- length=0, head=(2,3) -> on lines 48..63, hcount 32..47 gives rgb_out=12'h5C0 (2-cycle latency); all other pixels pass rgb_in.
- Head=(5,5), tail seg0=(5,5), length=1 -> cell shows 12'h5C0 (head priority); move seg0 to (6,5) -> cell 6 shows 12'h5D1.
- GRADIENT=1, length=5, seg4 at (10,2) -> 12'h5D5; GRADIENT=0 -> 12'h5D1; length=4 -> seg4 not drawn.
- Change head_x from 2 to 9 at line 300 -> frame unchanged until the next vsync rise, then cell 9 is drawn.
- Shorten hblank to 10 cycles with MAX_SEG=16 -> scan_overrun=1 and that line renders rgb_in; flag stays set until reset.
